// File: rtl/fp_normalize_round.sv
// Post-add normalize/round stage of the single-precision adder: takes an aligned raw sum, normalizes it
// one bit per clock, rounds to nearest-even and emits a packed IEEE-754 result over valid/ready.
module fp_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+4:0]         in_sig,
    input  logic                      in_nan,
    input  logic                      in_inf,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic                      flag_ovf,
    output logic                      flag_unf,
    output logic                      flag_inx,
    output logic [1:0]                dbg_state
);

    localparam int SIG_W  = FRAC_W + 5;
    localparam int MANT_W = FRAC_W + 2;
    localparam int XW     = EXP_W + 2;
    localparam int RES_W  = EXP_W + FRAC_W + 1;
    localparam logic [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [RES_W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Handshake rule on both sides: a transfer happens on a rising clk edge where valid and ready
    // are both high; a producer holds valid and its payload stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [XW-1:0]      exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inx_q, inx_d;

    // Rounding datapath, evaluated from the normalized registers while in ROUND
    logic               rnd_up;
    logic               rnd_inx;
    logic [MANT_W-1:0]  rnd_mant;
    logic               rnd_carry;
    logic               rnd_hidden;
    logic [FRAC_W-1:0]  rnd_frac;
    logic [XW-1:0]      rnd_exp;
    logic [EXP_W-1:0]   rnd_efield;
    logic               rnd_ovf;
    logic               rnd_zero;

    always_comb begin
        rnd_inx    = |sig_q[2:0];
        rnd_up     = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
        rnd_mant   = sig_q[SIG_W-1:3] + MANT_W'(rnd_up);
        rnd_carry  = rnd_mant[MANT_W-1];
        rnd_hidden = rnd_carry | rnd_mant[MANT_W-2];
        rnd_frac   = rnd_carry ? rnd_mant[MANT_W-2:1] : rnd_mant[FRAC_W-1:0];
        rnd_exp    = rnd_carry ? exp_q + EXP_ONE : exp_q;
        // A subnormal that rounds up into the hidden bit keeps exp 1, which is already the right field
        rnd_efield = rnd_hidden ? rnd_exp[EXP_W-1:0] : '0;
        rnd_ovf    = (rnd_exp >= EXP_MAX);
        rnd_zero   = (sig_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = (in_exp == '0) ? EXP_ONE : XW'(in_exp);
                    sig_d   = in_sig;
                    nan_d   = in_nan;
                    inf_d   = in_inf;
                    state_d = (in_nan | in_inf) ? S_ROUND : S_NORM;
                end
            end

            S_NORM: begin
                if (sig_q[SIG_W-1]) begin
                    // Carry out: fold the dropped bit into sticky
                    sig_d   = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else if (rnd_zero || sig_q[SIG_W-2] || exp_q == EXP_ONE) begin
                    state_d = S_ROUND;
                end else begin
                    sig_d   = {sig_q[SIG_W-2:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
                end
            end

            S_ROUND: begin
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inx_d   = 1'b0;
                state_d = S_OUT;
                if (nan_q) begin
                    result_d = QNAN;
                end else if (inf_q) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                end else if (rnd_zero) begin
                    result_d = {sign_q, {(RES_W-1){1'b0}}};
                end else if (rnd_ovf) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_efield, rnd_frac};
                    inx_d    = rnd_inx;
                    unf_d    = rnd_inx & (rnd_efield == '0);
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) & ~rst;
    assign out_valid = (state_q == S_OUT);
    assign result    = result_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;
    assign flag_inx  = inx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: directed corner cases plus randomized sums against an
// arithmetic reference model of normalize + round-to-nearest-even.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_sig;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] expf_q[$];
    int          explat_q[$];

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
        .in_nan(in_nan), .in_inf(in_inf),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Value-level model: find the leading one, shift it into place (bounded by exp 1), then RNE.
    function automatic void ref_model(input logic s, input logic [7:0] ex, input logic [27:0] sg,
                                      input logic nan, input logic inf,
                                      output logic [31:0] r, output logic [2:0] f, output int lat);
        longint sig, m, rem;
        int e, p, sh;
        logic [7:0] field;
        r = 32'h0;
        f = 3'b000;
        sh = 0;
        e = (ex == 8'd0) ? 1 : int'(ex);
        sig = longint'(sg);
        if (nan) begin r = 32'h7FC00000; lat = 1; return; end
        if (inf) begin r = {s, 8'hFF, 23'h0}; lat = 1; return; end
        if (sig >= (longint'(1) << 27)) begin
            sig = (sig >> 1) | (sig & 1);
            e = e + 1;
        end else if (sig != 0) begin
            p = 0;
            for (int i = 0; i < 27; i++) if (sig[i]) p = i;
            sh = 26 - p;
            if (sh > e - 1) sh = e - 1;
            sig = sig << sh;
            e = e - sh;
        end
        lat = sh + 2;
        if (sig == 0) begin r = {s, 31'h0}; return; end
        m = sig >> 3;
        rem = sig & 7;
        f[0] = (rem != 0);
        if (rem > 4 || (rem == 4 && m[0])) m = m + 1;
        if (m >= (longint'(1) << 24)) begin m = m >> 1; e = e + 1; end
        if (e >= 255) begin r = {s, 8'hFF, 23'h0}; f = 3'b101; return; end
        field = (m >= (longint'(1) << 23)) ? 8'(e) : 8'd0;
        r = {s, field, m[22:0]};
        f[1] = (field == 8'd0) && f[0];
    endfunction

    task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] sg,
                          input logic nan, input logic inf, input int stall);
        logic [31:0] r, want_r, want_f;
        logic [2:0]  f;
        int lat, cyc;
        ref_model(s, e, sg, nan, inf, r, f, lat);
        exp_q.push_back(r);
        expf_q.push_back({29'h0, f});
        explat_q.push_back(lat);

        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check("in_ready_idle", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = sg; in_nan = nan; in_inf = inf;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        // Busy-time junk on the input must be ignored
        in_sig = 28'($urandom); in_exp = 8'($urandom); in_sign = 1'($urandom);
        in_nan = ($urandom_range(0, 3) == 0); in_inf = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        in_valid = 1'b0;
        want_r = exp_q.pop_front();
        want_f = expf_q.pop_front();
        check("latency", 32'(cyc), 32'(explat_q.pop_front()));
        check("result", result, want_r);
        check("flags", {29'h0, flag_ovf, flag_unf, flag_inx}, want_f);
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk); #1;
                check("stall_valid", {31'h0, out_valid}, 32'h1);
                check("stall_result", result, want_r);
                check("stall_flags", {29'h0, flag_ovf, flag_unf, flag_inx}, want_f);
                check("stall_in_ready", {31'h0, in_ready}, 32'h0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_drop", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        logic        saw_valid;
        logic [27:0] sg;
        logic [7:0]  ex;
        int          mode;

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_sig = 28'd0;
        in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'h0, flag_ovf, flag_unf, flag_inx}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Directed cases
        run_op(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 0);
        check("one_plus_one", result, 32'h40000000);
        run_op(1'b0, 8'd130, 28'h0000008, 1'b0, 1'b0, 0);
        check("cancel", result, 32'h35800000);
        run_op(1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 0);
        check("tie_even", result, 32'h3F800000);
        run_op(1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0, 0);
        check("tie_odd", result, 32'h3F800002);
        run_op(1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0, 0);
        check("ovf_pos", result, 32'h7F800000);
        run_op(1'b1, 8'd254, 28'h8000000, 1'b0, 1'b0, 0);
        check("ovf_neg", result, 32'hFF800000);
        run_op(1'b0, 8'd1, 28'h2000000, 1'b0, 1'b0, 0);
        check("subn_exact", result, 32'h00400000);
        run_op(1'b0, 8'd1, 28'h2000006, 1'b0, 1'b0, 0);
        check("subn_inexact", result, 32'h00400001);
        run_op(1'b0, 8'd1, 28'h3FFFFFC, 1'b0, 1'b0, 0);
        check("subn_to_norm", result, 32'h00800000);
        run_op(1'b0, 8'd0, 28'h1000000, 1'b0, 1'b0, 0);
        run_op(1'b1, 8'd100, 28'h0000000, 1'b0, 1'b0, 0);
        check("zero_sign", result, 32'h80000000);
        run_op(1'b1, 8'd10, 28'h5555555, 1'b1, 1'b1, 0);
        check("nan", result, 32'h7FC00000);
        run_op(1'b1, 8'd10, 28'h5555555, 1'b0, 1'b1, 0);
        check("inf", result, 32'hFF800000);
        run_op(1'b0, 8'd150, 28'h7FFFFFF, 1'b0, 1'b0, 5);

        // Reset in the middle of a long normalization
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd130; in_sig = 28'h0000008;
        in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_result", result, 32'h0);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", {31'h0, in_ready}, 32'h1);
        saw_valid = 1'b0;
        repeat (30) begin @(posedge clk); #1; saw_valid |= out_valid; end
        check("aborted_no_output", {31'h0, saw_valid}, 32'h0);

        // Randomized sums
        for (int k = 0; k < 160; k++) begin
            mode = $urandom_range(0, 9);
            ex = 8'($urandom_range(0, 254));
            sg = 28'($urandom);
            case (mode)
                0: ;
                1: sg = {2'b01, 26'($urandom)};
                2: sg = {1'b1, 27'($urandom)};
                3: sg = 28'($urandom) >> $urandom_range(0, 27);
                4: begin ex = 8'($urandom_range(0, 5)); sg = 28'($urandom) >> $urandom_range(1, 27); end
                5: begin ex = 8'($urandom_range(250, 254)); sg = {1'b1, 27'($urandom)} | 28'h0FFFFF8; end
                6: sg = {2'b01, 23'h7FFFFF, 3'($urandom)};
                7: sg = 28'd0;
                default: sg = {2'b00, 26'($urandom)} >> $urandom_range(0, 8);
            endcase
            run_op(1'($urandom), ex, sg, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
